dot_matrix_arbiter: RTL
=======================

// Module: dot_matrix_arbiter
// PURPOSE
//  Owns the 8x16 dot-matrix frame buffer and schedules all access to it:
//  - refreshes the display one row per scan tick;
//  - arbitrates single-pixel writes from two requesters (A: keypad/cursor, B: game engine);
//  - sequences a whole-frame clear.
//  Sits between the game logic and the dotR/dotC pins, replacing ad-hoc pos[] writes.
// PARAMETERS
//  CLK_DIV   2500  clock cycles per scan tick (one row period); must be >= 2
//  NROWS     8     display rows (fixed by panel; idx row field 3 bits)
//  NCOLS     16    display columns (fixed by panel; idx col field 4 bits)
// PORTS
//  clock     in   1   system clock; single clock domain
//  reset     in   1   synchronous, active-high reset
//  a_req     in   1   requester A write request; held high until a_ack
//  a_idx     in   7   A pixel index: [6:4]=row, [3:0]=col
//  a_op      in   2   A operation: 00 clear, 01 set, 10 toggle, 11 no-op
//  a_ack     out  1   one-cycle pulse: A write committed
//  b_req     in   1   requester B write request
//  b_idx     in   7   B pixel index
//  b_op      in   2   B operation
//  b_ack     out  1   one-cycle pulse: B write committed
//  clr_req   in   1   start whole-frame clear (level sampled in IDLE)
//  clr_busy  out  1   high while clear sequence runs
//  rd_idx    in   7   pixel readback index
//  rd_bit    out  1   frame bit at rd_idx, registered (1-cycle latency)
//  dotR      out  8   row select, active-low one-hot; row r drives bit (7-r) low
//  dotC      out  16  column data for the selected row, active-high; bit c = col c
// BEHAVIOUR
//  - Reset: buffer all 0; dotR=8'hFF; dotC=0; a_ack=b_ack=0; clr_busy=0;
//    rd_bit=0; divider=0; scan row=0; RR pointer favours A; FSM=IDLE.
//  - Scan: divider counts 0..CLK_DIV-1 and wraps.
//    - At the terminal count: dotR <= one-hot-low(row); dotC <= buffer[row]; row <= row+1 (7 wraps to 0).
//    - First tick after reset shows row 0 (dotR=8'b01111111).
//    - dotC is a snapshot: a write to the displayed row appears on the row's next scan.
//  - Scan runs unaffected by writes and by clear.
//  - FSM states: IDLE, CLEAR.
//    - IDLE + clr_req=1 -> CLEAR with clr_row=0; clr_busy goes high the next cycle.
//    - CLEAR: zero buffer[clr_row] each cycle, clr_row++.
//    - CLEAR with clr_row==7 -> IDLE after zeroing row 7; clr_busy=1 for exactly 8 cycles.
//    - clr_req is ignored while in CLEAR.
//  - Writes are granted only in IDLE with clr_req=0; clear beats writes in the same cycle.
//    - Pending reqs wait, not dropped.
//  - Grant: at most one write per cycle.
//    - If only one req is high, it wins.
//    - If both are high, the one not granted last wins (round-robin pointer).
//    - The winner's buffer bit is updated on the same edge its ack rises; ack lasts 1 cycle.
//  - Requester must lower req or present new idx/op the cycle after ack.
//    - req still high that cycle = a new request, eligible immediately (RR applies).
//  - Ops: 00 bit<=0, 01 bit<=1, 10 bit<=~bit; 11 acked with no buffer change.
//  - Concurrent A and B to the same pixel are serialised by arbitration; never merged.
//  - rd_bit reflects the buffer value after the previous edge's writes (read-after-commit).
//  - Reset mid-clear or mid-handshake: aborts; acks 0; everything back to reset values.
// STRUCTURE
//  - Shared package dot_pkg:
//    - NROWS, NCOLS, IDX_W=7;
//    - op encodings OP_CLR/OP_SET/OP_TOG/OP_NOP;
//    - FSM state encoding;
//    - functions idx_row(idx), idx_col(idx).
//  - One sub-module dot_scan_timer (divider + row counter; outputs tick and row[2:0]).
//  - Arbiter, FSM and buffer stay in the top.
// TESTING (CLK_DIV=4 for sim)
//  1. Reset, no requests -> dotR=FF until first tick; ticks then show
//     dotR 7F,BF,DF,EF,F7,FB,FD,FE,7F; dotC=0.
//  2. A set idx=7'h13 (row1,col3) -> a_ack 1 cycle; rd_idx=13 -> rd_bit=1;
//     next row-1 scan dotC=16'h0008.
//  3. A and B both req, same cycle, 3 rounds (held high) -> grants A,B,A
//     from reset; each ack 1 cycle, never both.
//  4. Toggle 7'h7F twice via B -> rd_bit 1 then 0; row-7 scan dotC bit15 follows.
//  5. Fill rows 0-7 with set ops, assert clr_req with a_req pending -> clr_busy 8 cycles,
//     no ack during; a_ack 1 cycle after clr_busy falls; all rows 0 except A's pixel.
//  6. Assert reset mid-CLEAR (cycle 3) -> next cycle dotR=FF, dotC=0, clr_busy=0,
//     buffer all 0.

Source files
------------

// File: rtl/dot_matrix_arbiter_pkg.sv
// rtl/dot_matrix_arbiter_pkg.sv - shared types, sizes and index helpers for the dot-matrix arbiter
package dot_pkg;

  localparam int NROWS = 8;
  localparam int NCOLS = 16;
  localparam int IDX_W = 7;
  localparam int ROW_W = 3;
  localparam int COL_W = 4;

  typedef enum logic [1:0] {
    OP_CLR = 2'b00,
    OP_SET = 2'b01,
    OP_TOG = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Pixel index layout: [6:4] row, [3:0] column.
  function automatic logic [ROW_W-1:0] idx_row(input logic [IDX_W-1:0] idx);
    return idx[IDX_W-1:COL_W];
  endfunction

  function automatic logic [COL_W-1:0] idx_col(input logic [IDX_W-1:0] idx);
    return idx[COL_W-1:0];
  endfunction

endpackage

// File: rtl/dot_matrix_arbiter_if.sv
// rtl/dot_matrix_arbiter_if.sv - requester, clear and readback bundle of the dot-matrix arbiter
interface dot_matrix_arbiter_if;
  import dot_pkg::*;

  logic             a_req;
  logic [IDX_W-1:0] a_idx;
  logic [1:0]       a_op;
  logic             a_ack;
  logic             b_req;
  logic [IDX_W-1:0] b_idx;
  logic [1:0]       b_op;
  logic             b_ack;
  logic             clr_req;
  logic             clr_busy;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_bit;

  modport master (
    output a_req, a_idx, a_op, b_req, b_idx, b_op, clr_req, rd_idx,
    input  a_ack, b_ack, clr_busy, rd_bit
  );

  modport slave (
    input  a_req, a_idx, a_op, b_req, b_idx, b_op, clr_req, rd_idx,
    output a_ack, b_ack, clr_busy, rd_bit
  );

endinterface

// File: rtl/dot_scan_timer.sv
// rtl/dot_scan_timer.sv - row-period divider and scan row counter
module dot_scan_timer #(
  parameter int CLK_DIV = 2500
) (
  input  logic       clock,
  input  logic       reset,
  output logic       tick_o,
  output logic [2:0] row_o
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [2:0]       row_q;

  assign tick_o = (div_q == DIV_TERM);
  assign row_o  = row_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      row_q <= '0;
    end else if (tick_o) begin
      div_q <= '0;
      row_q <= row_q + 3'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dot_matrix_arbiter.sv
// rtl/dot_matrix_arbiter.sv - frame buffer owner: scan refresh, two-requester pixel writes, frame clear
module dot_matrix_arbiter
  import dot_pkg::*;
#(
  parameter int CLK_DIV = 2500
) (
  input  logic                    clock,
  input  logic                    reset,
  dot_matrix_arbiter_if.slave     bus,
  output logic [NROWS-1:0]        dotR,
  output logic [NCOLS-1:0]        dotC
);

  logic [NROWS-1:0][NCOLS-1:0] frame_q;
  state_e                      state_q;
  logic [ROW_W-1:0]            clr_row_q;
  logic                        clr_busy_q;
  logic                        a_ack_q;
  logic                        b_ack_q;
  logic                        rr_q;      // 0: A has priority on a tie, 1: B
  logic                        rd_bit_q;
  logic [NROWS-1:0]            dot_r_q;
  logic [NCOLS-1:0]            dot_c_q;

  logic                        tick;
  logic [ROW_W-1:0]            scan_row;
  logic                        grant_a;
  logic                        grant_b;
  logic [IDX_W-1:0]            w_idx;
  op_e                         w_op;
  logic [ROW_W-1:0]            w_row;
  logic [COL_W-1:0]            w_col;
  logic                        wr_bit_d;

  dot_scan_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .tick_o (tick),
    .row_o  (scan_row)
  );

  // Clear requests pre-empt writes; ties between A and B alternate.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_IDLE && !bus.clr_req) begin
      if (bus.a_req && (!bus.b_req || !rr_q)) begin
        grant_a = 1'b1;
      end else if (bus.b_req) begin
        grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    w_idx    = grant_b ? bus.b_idx : bus.a_idx;
    w_op     = op_e'(grant_b ? bus.b_op : bus.a_op);
    w_row    = idx_row(w_idx);
    w_col    = idx_col(w_idx);
    wr_bit_d = frame_q[w_row][w_col];
    case (w_op)
      OP_CLR:  wr_bit_d = 1'b0;
      OP_SET:  wr_bit_d = 1'b1;
      OP_TOG:  wr_bit_d = ~frame_q[w_row][w_col];
      default: wr_bit_d = frame_q[w_row][w_col];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q    <= '0;
      state_q    <= ST_IDLE;
      clr_row_q  <= '0;
      clr_busy_q <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      a_ack_q <= grant_a;
      b_ack_q <= grant_b;
      case (state_q)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_q    <= ST_CLEAR;
            clr_row_q  <= '0;
            clr_busy_q <= 1'b1;
          end else if (grant_a || grant_b) begin
            frame_q[w_row][w_col] <= wr_bit_d;
            rr_q                  <= grant_a;
          end
        end
        ST_CLEAR: begin
          frame_q[clr_row_q] <= '0;
          clr_row_q          <= clr_row_q + 3'd1;
          if (clr_row_q == ROW_W'(NROWS - 1)) begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Readback and display latch the buffer as it stood before this edge's update.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_bit_q <= 1'b0;
      dot_r_q  <= '1;
      dot_c_q  <= '0;
    end else begin
      rd_bit_q <= frame_q[idx_row(bus.rd_idx)][idx_col(bus.rd_idx)];
      if (tick) begin
        dot_r_q <= ~(NROWS'(1) << (NROWS - 1 - int'(scan_row)));
        dot_c_q <= frame_q[scan_row];
      end
    end
  end

  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.rd_bit   = rd_bit_q;
  assign dotR         = dot_r_q;
  assign dotC         = dot_c_q;

endmodule
